// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: Moore outputs decoded from the state register.
// Optional feature: define MC_ADDI_EN to add the ADDIEX/ADDIWB path for addi.
module mc_main_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               memToReg,
    output logic               regDst,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluOp,
    output logic [1:0]         pcSource,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        MEMADR = STATE_W'(2),
        MEMRD  = STATE_W'(3),
        MEMWB  = STATE_W'(4),
        MEMWR  = STATE_W'(5),
        EXEC   = STATE_W'(6),
        ALUWB  = STATE_W'(7),
        BRANCH = STATE_W'(8),
        JUMP   = STATE_W'(9),
        ADDIEX = STATE_W'(10),
        ADDIWB = STATE_W'(11)
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_e state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:  state_q <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_RTYPE:     state_q <= EXEC;
                        OP_BEQ:       state_q <= BRANCH;
                        OP_J:         state_q <= JUMP;
`ifdef MC_ADDI_EN
                        OP_ADDI:      state_q <= ADDIEX;
`endif
                        default:      state_q <= FETCH;
                    endcase
                end
                MEMADR: state_q <= (opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  state_q <= MEMWB;
                EXEC:   state_q <= ALUWB;
`ifdef MC_ADDI_EN
                ADDIEX: state_q <= ADDIWB;
`endif
                default: state_q <= FETCH;
            endcase
        end
    end

    // Outputs gated by rst so write strobes drop the moment reset asserts.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'd0;
        aluOp       = 2'd0;
        pcSource    = 2'd0;
        state       = '0;
        if (!rst) begin
            state = state_q;
            case (state_q)
                FETCH: begin
                    memRead = 1'b1;
                    irWrite = 1'b1;
                    aluSrcB = 2'd1;
                    pcWrite = 1'b1;
                end
                DECODE: aluSrcB = 2'd3;
                MEMADR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'd2;
                end
                MEMRD: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                end
                MEMWB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                end
                MEMWR: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                end
                EXEC: begin
                    aluSrcA = 1'b1;
                    aluOp   = 2'd2;
                end
                ALUWB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                end
                BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluOp       = 2'd1;
                    pcWriteCond = 1'b1;
                    pcSource    = 2'd1;
                end
                JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = 2'd2;
                end
`ifdef MC_ADDI_EN
                ADDIEX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'd2;
                end
                ADDIWB: regWrite = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: per-state sequence and control-word checks.
module tb_mc_main_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    int n_cmp;
    int n_bad;

    mc_main_control #(.STATE_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memToReg    (memToReg),
        .regDst      (regDst),
        .regWrite    (regWrite),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .aluOp       (aluOp),
        .pcSource    (pcSource),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,
    //  memToReg,regDst,regWrite,aluSrcA,aluSrcB,aluOp,pcSource}
    function automatic logic [15:0] ctrl_now();
        return {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
                pcSource};
    endfunction

    // Hand-written from the per-state output table.
    function automatic logic [15:0] ctrl_exp(input int s);
        case (s)
            0:  return 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
            1:  return 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
            2:  return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
            3:  return 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
            4:  return 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
            5:  return 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
            6:  return 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
            7:  return 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
            8:  return 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
            9:  return 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
            10: return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
            11: return 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
            default: return 16'h0000;
        endcase
    endfunction

    // Called just after a negedge with the DUT in FETCH; ends in the next FETCH.
    task automatic run(input string name, input logic [5:0] op,
                       input int seq[$], input int exp_rw,
                       input int exp_mw);
        int rw_cnt;
        int mw_cnt;
        rw_cnt = 0;
        mw_cnt = 0;
        opcode = op;
        for (int i = 0; i < seq.size(); i++) begin
            check($sformatf("%s state[%0d]", name, i), 32'(state),
                  32'(seq[i]));
            check($sformatf("%s ctrl[%0d]", name, i), 32'(ctrl_now()),
                  32'(ctrl_exp(seq[i])));
            if (i < seq.size() - 1) begin
                rw_cnt += int'(regWrite);
                mw_cnt += int'(memWrite);
                @(negedge clk);
                #1;
            end
        end
        check({name, " regWrite cycles"}, 32'(rw_cnt), 32'(exp_rw));
        check({name, " memWrite cycles"}, 32'(mw_cnt), 32'(exp_mw));
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        opcode = 6'b000000;
        #2;
        check("reset state", 32'(state), 32'd0);
        check("reset ctrl", 32'(ctrl_now()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset held ctrl", 32'(ctrl_now()), 32'd0);
        rst = 1'b0;
        #1;
        check("release fetch ctrl", 32'(ctrl_now()), 32'(ctrl_exp(0)));

        run("lw",   6'b100011, '{0, 1, 2, 3, 4, 0}, 1, 0);
        run("sw",   6'b101011, '{0, 1, 2, 5, 0},    0, 1);
        run("rtype", 6'b000000, '{0, 1, 6, 7, 0},   1, 0);
        run("beq",  6'b000100, '{0, 1, 8, 0},       0, 0);
        run("j",    6'b000010, '{0, 1, 9, 0},       0, 0);
`ifdef MC_ADDI_EN
        run("addi", 6'b001000, '{0, 1, 10, 11, 0},  1, 0);
`else
        run("addi", 6'b001000, '{0, 1, 0},          0, 0);
`endif
        run("undef", 6'b111111, '{0, 1, 0},         0, 0);

        // Abort an R-type in ALUWB with an asynchronous reset.
        opcode = 6'b000000;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("pre-abort state", 32'(state), 32'd7);
        check("pre-abort regWrite", 32'(regWrite), 32'd1);
        rst = 1'b1;
        #1;
        check("abort regWrite", 32'(regWrite), 32'd0);
        check("abort state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        check("abort held ctrl", 32'(ctrl_now()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-abort state", 32'(state), 32'd0);
        check("post-abort mr/ir/pw", 32'({memRead, irWrite, pcWrite}),
              32'b111);
        run("rtype2", 6'b000000, '{0, 1, 6, 7, 0}, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Main control state machine for the multi-cycle MIPS datapath. It sits directly upstream of the register file and produces `regWrite` and the write-address and write-data select lines the register file consumes. It sequences every instruction through fetch, decode, execute, memory and writeback steps from the 6-bit opcode in the instruction register. All outputs are Moore, decoded from the state register only.

## Interface
Parameters:
- `STATE_W`, default 4: state register width; it must be at least 4.

Ports:
- `clk`, input, 1 bit: rising-edge clock for the state register.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `opcode`, input, 6 bits: IR[31:26], valid from DECODE onward.
- `pcWrite`, output, 1 bit: unconditional PC load.
- `pcWriteCond`, output, 1 bit: PC load qualified by ALU zero (beq).
- `iorD`, output, 1 bit: memory address select (0 = PC, 1 = ALUOut).
- `memRead`, output, 1 bit: memory read strobe.
- `memWrite`, output, 1 bit: memory write strobe.
- `irWrite`, output, 1 bit: instruction register load.
- `memToReg`, output, 1 bit: register-file write data select (0 = ALUOut, 1 = MDR).
- `regDst`, output, 1 bit: register-file write address select (0 = rt, 1 = rd).
- `regWrite`, output, 1 bit: register-file write enable.
- `aluSrcA`, output, 1 bit: ALU A select (0 = PC, 1 = A reg).
- `aluSrcB`, output, 2 bits: ALU B select (0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2).
- `aluOp`, output, 2 bits: ALU control class (0 = add, 1 = sub, 2 = funct-decoded).
- `pcSource`, output, 2 bits: PC mux select (0 = ALU, 1 = ALUOut, 2 = jump target).
- `state`, output, STATE_W bits: current state, for debug and bench.

## Operation
State encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11.
- Unused encodings 12–15 go to FETCH on the next edge, and all outputs are 0 while in them.

Transitions:
- FETCH always goes to DECODE.
- DECODE goes to the next state by opcode:
  - lw (100011) or sw (101011) → MEMADR.
  - R-type (000000) → EXEC.
  - beq (000100) → BRANCH.
  - j (000010) → JUMP.
  - addi (001000) → ADDIEX.
  - Any other opcode → FETCH. The instruction is skipped and no write occurs.
- MEMADR → MEMRD if the opcode is lw, otherwise MEMWR.
- MEMRD → MEMWB.
- EXEC → ALUWB.
- ADDIEX → ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP all go to FETCH.

Outputs asserted per state (anything not listed is 0):
- FETCH: memRead, irWrite, aluSrcB = 1, pcWrite, pcSource = 0.
- DECODE: aluSrcB = 3.
- MEMADR: aluSrcA, aluSrcB = 2.
- MEMRD: memRead, iorD.
- MEMWB: regWrite, memToReg, regDst = 0.
- MEMWR: memWrite, iorD.
- EXEC: aluSrcA, aluOp = 2.
- ALUWB: regWrite, regDst = 1, memToReg = 0.
- BRANCH: aluSrcA, aluOp = 1, pcWriteCond, pcSource = 1.
- JUMP: pcWrite, pcSource = 2.
- ADDIEX: aluSrcA, aluSrcB = 2.
- ADDIWB: regWrite, regDst = 0, memToReg = 0.

## Timing
- Reset: while `rst` = 1, state = FETCH and every output is forced to 0, including `state`. FETCH outputs appear combinationally once `rst` falls.
- Reset asserted mid-instruction aborts the instruction immediately. Any pending write strobe drops in the same cycle.
- Cycles per instruction, counted from entry to FETCH:
  - lw: 5.
  - sw, R-type and addi: 4.
  - beq and j: 3.
  - Undefined opcode: 2.
- `regWrite` is high for exactly one clk cycle per writing instruction. It is stable across the falling edge in the middle of that cycle, which is where the register file commits.
- `memWrite` is high for exactly one cycle per sw.
- `irWrite` is high only in FETCH, so the opcode is held for the rest of the instruction.

## Configuration
- `MC_ADDI_EN` defined: the ADDIEX and ADDIWB states exist, and addi executes as described above.
- `MC_ADDI_EN` undefined: opcode 001000 is treated as undefined (DECODE → FETCH). Encodings 10 and 11 become unused and return to FETCH.

## Test plan
- Reset during ALUWB: `regWrite` drops to 0 asynchronously. After release, `state` = 0 with memRead = 1, irWrite = 1, pcWrite = 1.
- opcode = 100011 (lw): state sequence 0, 1, 2, 3, 4, 0. `regWrite` = 1 and `memToReg` = 1 only in state 4.
- opcode = 101011 (sw): state sequence 0, 1, 2, 5, 0. `memWrite` pulses once, and `regWrite` stays 0 throughout.
- opcode = 000000 (R-type): state sequence 0, 1, 6, 7, 0. aluOp = 2 in state 6; regDst = 1 and regWrite = 1 in state 7.
- opcode = 000100 (beq) then 000010 (j): sequences 0, 1, 8, 0 then 0, 1, 9, 0. pcWriteCond = 1 and pcSource = 1 in state 8; pcSource = 2 and pcWrite = 1 in state 9.
- opcode = 001000 (addi): with `MC_ADDI_EN` the sequence is 0, 1, 10, 11, 0 with regWrite = 1 in state 11; without it the sequence is 0, 1, 0. opcode = 111111: sequence 0, 1, 0 with no write strobe.
